intr_ctrl: RTL and testbench

INTR_CTRL -- requirements
Module: intr_ctrl

---
 rtl/intr_ctrl_pkg.sv | 20 ++
 rtl/intr_ctrl_if.sv | 13 +
 rtl/intr_prio_enc.sv | 22 ++
 rtl/intr_ctrl.sv | 115 +++++++++++
 tb/tb_intr_ctrl.sv | 179 +++++++++++++++++
 5 files changed

// File: rtl/intr_ctrl_pkg.sv
// Shared constants for the interrupt controller: register offsets, ICTRL bit
// positions, FSM encoding and source-ID width.
package intr_ctrl_pkg;
  localparam int OFF_IMASK = 0;
  localparam int OFF_IPEND = 4;
  localparam int OFF_ICTRL = 8;
  localparam int OFF_EOI   = 12;

  localparam int ICTRL_GIE    = 0;
  localparam int ICTRL_INSVC  = 1;
  localparam int ICTRL_ID_LSB = 4;

  localparam int ID_W = 4;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_REQ     = 2'd1,
    ST_SERVICE = 2'd2
  } state_t;
endpackage

// File: rtl/intr_ctrl_if.sv
// CPU-side bus and interrupt handshake signals of the interrupt controller.
// DBUS is bidirectional and stays a plain port on the controller.
interface intr_ctrl_if #(parameter int BITS = 32);
  import intr_ctrl_pkg::*;
  logic [BITS-1:0] ABUS;
  logic            WE;
  logic            INTA;
  logic            IRQ;
  logic [ID_W-1:0] IRQ_ID;

  modport master (output ABUS, WE, INTA, input IRQ, IRQ_ID);
  modport slave  (input ABUS, WE, INTA, output IRQ, IRQ_ID);
endinterface

// File: rtl/intr_prio_enc.sv
// Lowest-index-wins priority encoder; o_vld flags a non-empty request vector.
module intr_prio_enc
  import intr_ctrl_pkg::*;
#(
  parameter int N_SRC = 4
) (
  input  logic [N_SRC-1:0] i_req,
  output logic [ID_W-1:0]  o_id,
  output logic             o_vld
);
  // Scan from the top so the lowest set index is the last one written.
  always_comb begin
    o_id  = '0;
    o_vld = 1'b0;
    for (int i = N_SRC - 1; i >= 0; i--) begin
      if (i_req[i]) begin
        o_id  = ID_W'(i);
        o_vld = 1'b1;
      end
    end
  end
endmodule

// File: rtl/intr_ctrl.sv
// Memory-mapped interrupt controller: edge-detected pending bits, mask, global
// enable, fixed-priority arbitration and an IDLE/REQ/SERVICE handshake FSM.
module intr_ctrl
  import intr_ctrl_pkg::*;
#(
  parameter int          BITS  = 32,
  parameter int          N_SRC = 4,
  parameter logic [31:0] BASE  = 32'hFFFFF100
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic [N_SRC-1:0] IRQ_IN,
  inout  wire  [BITS-1:0]  DBUS,
  intr_ctrl_if.slave       bus
);
  localparam logic [BITS-1:0] A_IMASK = BITS'(BASE + OFF_IMASK);
  localparam logic [BITS-1:0] A_IPEND = BITS'(BASE + OFF_IPEND);
  localparam logic [BITS-1:0] A_ICTRL = BITS'(BASE + OFF_ICTRL);
  localparam logic [BITS-1:0] A_EOI   = BITS'(BASE + OFF_EOI);

  state_t           r_state;
  logic [N_SRC-1:0] r_imask, r_ipend, r_prev;
  logic             r_gie, r_irq;
  logic [ID_W-1:0]  r_irq_id;

  logic             w_sel_imask, w_sel_ipend, w_sel_ictrl, w_sel_eoi;
  logic             w_wr_imask, w_wr_ipend, w_wr_ictrl, w_wr_eoi, w_rd_en;
  logic             w_inta_acc, w_gie_nxt, w_win_vld;
  logic [N_SRC-1:0] w_rise, w_clr, w_id_oh, w_ipend_nxt, w_imask_nxt;
  logic [N_SRC-1:0] w_elig, w_elig_nxt;
  logic [ID_W-1:0]  w_win_id;
  logic [BITS-1:0]  w_rdata;
  wire              w_unused_dbus = ^DBUS;

  assign w_sel_imask = (bus.ABUS == A_IMASK);
  assign w_sel_ipend = (bus.ABUS == A_IPEND);
  assign w_sel_ictrl = (bus.ABUS == A_ICTRL);
  assign w_sel_eoi   = (bus.ABUS == A_EOI);
  assign w_wr_imask  = w_sel_imask & bus.WE;
  assign w_wr_ipend  = w_sel_ipend & bus.WE;
  assign w_wr_ictrl  = w_sel_ictrl & bus.WE;
  assign w_wr_eoi    = w_sel_eoi & bus.WE;
  assign w_rd_en     = ~bus.WE & (w_sel_imask | w_sel_ipend | w_sel_ictrl);

  assign w_rise      = IRQ_IN & ~r_prev;
  assign w_inta_acc  = (r_state == ST_REQ) & bus.INTA;
  assign w_id_oh     = N_SRC'(1) << r_irq_id;
  assign w_clr       = (w_wr_ipend ? DBUS[N_SRC-1:0] : '0) | (w_inta_acc ? w_id_oh : '0);
  // A new edge overrides any clear landing in the same cycle.
  assign w_ipend_nxt = (r_ipend & ~w_clr) | w_rise;
  assign w_imask_nxt = w_wr_imask ? DBUS[N_SRC-1:0] : r_imask;
  assign w_gie_nxt   = w_wr_ictrl ? DBUS[ICTRL_GIE] : r_gie;

  assign w_elig      = r_gie ? (r_ipend & r_imask) : '0;
  // REQ abandons the request as soon as the latched source loses eligibility,
  // so a mask/GIE/W1C write drops IRQ on the very next cycle.
  assign w_elig_nxt  = w_gie_nxt ? (w_ipend_nxt & w_imask_nxt) : '0;

  intr_prio_enc #(.N_SRC(N_SRC)) u_prio (
    .i_req (w_elig),
    .o_id  (w_win_id),
    .o_vld (w_win_vld)
  );

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      r_imask  <= '0;
      r_ipend  <= '0;
      r_prev   <= '0;
      r_gie    <= 1'b0;
      r_state  <= ST_IDLE;
      r_irq    <= 1'b0;
      r_irq_id <= '0;
    end else begin
      r_prev  <= IRQ_IN;
      r_ipend <= w_ipend_nxt;
      r_imask <= w_imask_nxt;
      r_gie   <= w_gie_nxt;
      case (r_state)
        ST_IDLE: if (w_win_vld) begin
          r_state  <= ST_REQ;
          r_irq    <= 1'b1;
          r_irq_id <= w_win_id;
        end
        ST_REQ: if (w_inta_acc) begin
          r_state <= ST_SERVICE;
          r_irq   <= 1'b0;
        end else if (~|(w_elig_nxt & w_id_oh)) begin
          r_state <= ST_IDLE;
          r_irq   <= 1'b0;
        end
        ST_SERVICE: if (w_wr_eoi) r_state <= ST_IDLE;
        default: begin
          r_state <= ST_IDLE;
          r_irq   <= 1'b0;
        end
      endcase
    end
  end

  always_comb begin
    w_rdata = '0;
    if (w_sel_imask) w_rdata[N_SRC-1:0] = r_imask;
    if (w_sel_ipend) w_rdata[N_SRC-1:0] = r_ipend;
    if (w_sel_ictrl) begin
      w_rdata[ICTRL_GIE]                     = r_gie;
      w_rdata[ICTRL_INSVC]                   = (r_state == ST_SERVICE);
      w_rdata[ICTRL_ID_LSB +: ID_W]          = r_irq_id;
    end
  end

  assign DBUS       = w_rd_en ? w_rdata : {BITS{1'bz}};
  assign bus.IRQ    = r_irq;
  assign bus.IRQ_ID = r_irq_id;
endmodule

// File: tb/tb_intr_ctrl.sv
// Directed bench for intr_ctrl: register access, edge capture, arbitration,
// REQ/SERVICE handshake, W1C/edge collision and asynchronous reset.
module tb_intr_ctrl;
  localparam int          BITS = 32;
  localparam logic [31:0] BASE = 32'hFFFFF100;
  localparam logic [31:0] A_IMASK = BASE;
  localparam logic [31:0] A_IPEND = BASE + 4;
  localparam logic [31:0] A_ICTRL = BASE + 8;
  localparam logic [31:0] A_EOI   = BASE + 12;

  logic        CLK = 1'b0;
  logic        RST = 1'b1;
  logic [3:0]  IRQ_IN = '0;
  wire  [31:0] DBUS;
  logic [31:0] drv_d = '0;
  logic        drv_en = 1'b0;
  int          n_chk = 0;
  int          n_err = 0;

  intr_ctrl_if #(.BITS(BITS)) bus();
  assign DBUS = drv_en ? drv_d : 32'hzzzz_zzzz;

  intr_ctrl #(.BITS(BITS), .N_SRC(4), .BASE(BASE)) dut (
    .CLK    (CLK),
    .RST    (RST),
    .IRQ_IN (IRQ_IN),
    .DBUS   (DBUS),
    .bus    (bus)
  );

  always #5 CLK = ~CLK;

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic wr(input logic [31:0] a, input logic [31:0] v);
    bus.ABUS = a; bus.WE = 1'b1; drv_en = 1'b1; drv_d = v;
    tick();
    bus.WE = 1'b0; drv_en = 1'b0; bus.ABUS = '0;
  endtask

  task automatic rdchk(input string tag, input logic [31:0] a, input logic [31:0] exp);
    logic [31:0] v;
    bus.ABUS = a; bus.WE = 1'b0;
    #1;
    v = DBUS;
    bus.ABUS = '0;
    chk(tag, v, exp);
  endtask

  initial begin
    bus.ABUS = '0; bus.WE = 1'b0; bus.INTA = 1'b0;
    tick(); tick();
    chk("rst_irq", {31'b0, bus.IRQ}, 0);
    chk("rst_id", {28'b0, bus.IRQ_ID}, 0);
    RST = 1'b0;
    tick();
    rdchk("rst_imask", A_IMASK, 0);
    rdchk("rst_ipend", A_IPEND, 0);
    rdchk("rst_ictrl", A_ICTRL, 0);

    // Single source latency: edge at n, IPEND at n+1, IRQ at n+2
    wr(A_ICTRL, 32'h1);
    wr(A_IMASK, 32'h4);
    rdchk("imask_rb", A_IMASK, 32'h4);
    IRQ_IN = 4'b0100;
    tick();
    rdchk("lat_ipend", A_IPEND, 32'h4);
    chk("lat_irq_n1", {31'b0, bus.IRQ}, 0);
    tick();
    IRQ_IN = '0;
    chk("lat_irq_n2", {31'b0, bus.IRQ}, 1);
    chk("lat_id", {28'b0, bus.IRQ_ID}, 2);
    rdchk("req_ictrl", A_ICTRL, 32'h21);

    // Masking the latched source in REQ abandons the request
    wr(A_IMASK, 32'h0);
    chk("mask_irq", {31'b0, bus.IRQ}, 0);
    rdchk("mask_ipend", A_IPEND, 32'h4);
    rdchk("mask_ictrl", A_ICTRL, 32'h21);
    tick();
    chk("mask_irq2", {31'b0, bus.IRQ}, 0);
    wr(A_IPEND, 32'h4);
    rdchk("w1c_ipend", A_IPEND, 32'h0);

    // Two simultaneous sources, service and EOI
    wr(A_IMASK, 32'ha);
    IRQ_IN = 4'b1010;
    tick();
    IRQ_IN = '0;
    rdchk("two_ipend", A_IPEND, 32'ha);
    tick();
    chk("two_irq", {31'b0, bus.IRQ}, 1);
    chk("two_id", {28'b0, bus.IRQ_ID}, 1);
    bus.INTA = 1'b1;
    tick();
    bus.INTA = 1'b0;
    chk("inta_irq", {31'b0, bus.IRQ}, 0);
    rdchk("inta_ipend", A_IPEND, 32'h8);
    rdchk("svc_ictrl", A_ICTRL, 32'h13);
    tick();
    chk("svc_nonest", {31'b0, bus.IRQ}, 0);
    wr(A_EOI, 32'hdead);
    chk("eoi_irq_m1", {31'b0, bus.IRQ}, 0);
    tick();
    chk("eoi_irq_m2", {31'b0, bus.IRQ}, 1);
    chk("eoi_id", {28'b0, bus.IRQ_ID}, 3);
    bus.INTA = 1'b1;
    tick();
    bus.INTA = 1'b0;
    rdchk("inta2_ipend", A_IPEND, 32'h0);
    wr(A_EOI, 32'h0);
    rdchk("eoi2_ictrl", A_ICTRL, 32'h31);

    // INTA in IDLE is ignored; undecoded write is ignored
    wr(A_IMASK, 32'h0);
    IRQ_IN = 4'b0001;
    tick();
    IRQ_IN = '0;
    bus.INTA = 1'b1;
    tick();
    bus.INTA = 1'b0;
    rdchk("idle_inta_ipend", A_IPEND, 32'h1);
    chk("idle_inta_irq", {31'b0, bus.IRQ}, 0);
    wr(BASE + 16, 32'hffff_ffff);
    rdchk("undec_imask", A_IMASK, 32'h0);

    // W1C collides with a fresh edge: the edge wins
    IRQ_IN = 4'b0001;
    wr(A_IPEND, 32'h1);
    rdchk("w1c_edge", A_IPEND, 32'h1);
    wr(A_IPEND, 32'h1);
    rdchk("w1c_held", A_IPEND, 32'h0);
    IRQ_IN = '0;

    // Asynchronous reset during SERVICE
    wr(A_IMASK, 32'h1);
    IRQ_IN = 4'b0001;
    tick();
    IRQ_IN = '0;
    tick();
    chk("s0_irq", {31'b0, bus.IRQ}, 1);
    bus.INTA = 1'b1;
    tick();
    bus.INTA = 1'b0;
    rdchk("s0_ictrl", A_ICTRL, 32'h03);
    #1;
    RST = 1'b1;
    IRQ_IN = 4'b0010;
    #1;
    chk("arst_irq", {31'b0, bus.IRQ}, 0);
    rdchk("arst_imask", A_IMASK, 32'h0);
    rdchk("arst_ictrl", A_ICTRL, 32'h0);
    tick(); tick();
    RST = 1'b0;

    // Line held high across reset release registers exactly one edge
    tick();
    rdchk("rel_ipend", A_IPEND, 32'h2);
    wr(A_IPEND, 32'h2);
    tick();
    rdchk("rel_noedge", A_IPEND, 32'h0);
    IRQ_IN = '0;
    tick();

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end
endmodule
